// File: rtl/mixcol_arbiter.sv
// mixcol_arbiter
// Two requesters share one column-serial AES MixColumns engine. A round-robin
// arbiter in IDLE picks a requester and captures its 128-bit state. The engine
// then transforms one 32-bit column per cycle for four cycles. The result is
// held in DONE until the consumer takes it, tagged with the owning requester.
//
// Build option: define MIXCOL_INV_EN to add req0_inv/req1_inv ports. A request
// captured with inv=1 uses the inverse MixColumns matrix. Without the macro,
// the forward matrix is always used.

module mixcol_arbiter #(
    parameter int NUM_COLS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_state,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_state,
`ifdef MIXCOL_INV_EN
    input  logic         req0_inv,
    input  logic         req1_inv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         out_id,
    output logic         busy
);

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Index of the final column; its edge moves the FSM from BUSY to DONE
    localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);

    // ------------------------------------------------------------------
    // GF(2^8) helpers, reduction polynomial 0x11b
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward circulant {02,03,01,01}; byte 0 sits at the MSB of the column
    function automatic logic [31:0] mixForward(input logic [31:0] col);
        logic [7:0] b0, b1, b2, b3;
        logic [7:0] r0, r1, r2, r3;
        b0 = col[31:24];
        b1 = col[23:16];
        b2 = col[15:8];
        b3 = col[7:0];
        r0 = xtime(b0) ^ (xtime(b1) ^ b1) ^ b2 ^ b3;
        r1 = b0 ^ xtime(b1) ^ (xtime(b2) ^ b2) ^ b3;
        r2 = b0 ^ b1 ^ xtime(b2) ^ (xtime(b3) ^ b3);
        r3 = (xtime(b0) ^ b0) ^ b1 ^ b2 ^ xtime(b3);
        return {r0, r1, r2, r3};
    endfunction

`ifdef MIXCOL_INV_EN
    // Multiply by 09, 0b, 0d and 0e, built from repeated doubling
    function automatic logic [7:0] mul09(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction

    // Inverse circulant {0e,0b,0d,09}
    function automatic logic [31:0] mixInverse(input logic [31:0] col);
        logic [7:0] b0, b1, b2, b3;
        logic [7:0] r0, r1, r2, r3;
        b0 = col[31:24];
        b1 = col[23:16];
        b2 = col[15:8];
        b3 = col[7:0];
        r0 = mul0e(b0) ^ mul0b(b1) ^ mul0d(b2) ^ mul09(b3);
        r1 = mul09(b0) ^ mul0e(b1) ^ mul0b(b2) ^ mul0d(b3);
        r2 = mul0d(b0) ^ mul09(b1) ^ mul0e(b2) ^ mul0b(b3);
        r3 = mul0b(b0) ^ mul0d(b1) ^ mul09(b2) ^ mul0e(b3);
        return {r0, r1, r2, r3};
    endfunction
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]   r_state;
    logic [1:0]   r_colCnt;
    logic [127:0] r_work;
    logic [127:0] r_outState;
    logic         r_outId;
    logic         r_outValid;
    logic         r_lastGrant;
`ifdef MIXCOL_INV_EN
    logic         r_inv;
`endif

    logic         w_idle;
    logic         w_grant;
    logic         w_accept;
    logic [31:0]  w_col;
    logic [31:0]  w_mixed;

    assign w_idle = (r_state == S_IDLE);

    // Round-robin pick: a lone requester wins; on a tie, the one not served last wins
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_lastGrant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    // Readies only in IDLE, so a DONE handshake can never overlap a new accept
    assign req0_ready = w_idle && !w_grant && req0_valid;
    assign req1_ready = w_idle &&  w_grant && req1_valid;
    assign w_accept   = req0_ready || req1_ready;

    // Select the column of the work register that the engine handles this cycle
    always_comb begin
        w_col = r_work[127:96];
        case (r_colCnt)
            2'd0:    w_col = r_work[127:96];
            2'd1:    w_col = r_work[95:64];
            2'd2:    w_col = r_work[63:32];
            2'd3:    w_col = r_work[31:0];
            default: w_col = r_work[127:96];
        endcase
    end

    // Column mixer, with direction chosen by the captured inv bit when enabled
    always_comb begin
`ifdef MIXCOL_INV_EN
        w_mixed = r_inv ? mixInverse(w_col) : mixForward(w_col);
`else
        w_mixed = mixForward(w_col);
`endif
    end

    // Control FSM: IDLE -> BUSY (four column cycles) -> DONE -> IDLE on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_colCnt <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= S_BUSY;
                        r_colCnt <= 2'd0;
                    end
                end
                S_BUSY: begin
                    r_colCnt <= r_colCnt + 2'd1;
                    if (r_colCnt == LAST_COL) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_colCnt <= 2'd0;
                end
            endcase
        end
    end

    // Capture the granted requester's state (and direction) on the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
`ifdef MIXCOL_INV_EN
            r_inv  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_work <= req1_ready ? req1_state : req0_state;
`ifdef MIXCOL_INV_EN
            r_inv  <= req1_ready ? req1_inv : req0_inv;
`endif
        end
    end

    // Result columns, owner tag, fairness memory and the output valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outState  <= '0;
            r_outId     <= 1'b0;
            r_outValid  <= 1'b0;
            r_lastGrant <= 1'b1;
        end else begin
            if (w_accept) begin
                r_outId     <= req1_ready;
                r_lastGrant <= req1_ready;
            end
            if (r_state == S_BUSY) begin
                case (r_colCnt)
                    2'd0:    r_outState[127:96] <= w_mixed;
                    2'd1:    r_outState[95:64]  <= w_mixed;
                    2'd2:    r_outState[63:32]  <= w_mixed;
                    2'd3:    r_outState[31:0]   <= w_mixed;
                    default: r_outState[127:96] <= w_mixed;
                endcase
                if (r_colCnt == LAST_COL) begin
                    r_outValid <= 1'b1;
                end
            end
            if ((r_state == S_DONE) && r_outValid && out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign out_valid = r_outValid;
    assign out_state = r_outState;
    assign out_id    = r_outId;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mixcol_arbiter.sv
// tb_mixcol_arbiter
// Drives the shared MixColumns arbiter cycle by cycle. Each cycle is compared
// against a transaction-level model that uses generic GF(2^8) matrix arithmetic
// and a countdown of edges until the result. Define MIXCOL_INV_EN to also cover
// the inverse transform.

module tb_mixcol_arbiter;

`ifdef MIXCOL_INV_EN
    localparam bit INV_ON = 1'b1;
`else
    localparam bit INV_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_state, req1_state;
    logic         req0_inv, req1_inv;
    logic         out_valid, out_ready, out_id, busy;
    logic [127:0] out_state;

    int checks = 0;
    int errors = 0;

    // Reference model: edges left before the result appears, plus the pending result
    int           mBusyLeft;
    bit           mOutValid;
    logic [127:0] mExpState;
    logic         mExpId;
    logic         mLastGrant;

    // Results actually handed over by the DUT (out_valid && out_ready)
    logic [127:0] outStates[$];
    logic         outIds[$];

    mixcol_arbiter #(.NUM_COLS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_state (req0_state),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_state (req1_state),
`ifdef MIXCOL_INV_EN
        .req0_inv   (req0_inv),
        .req1_inv   (req1_inv),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_state  (out_state),
        .out_id     (out_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Carry-less polynomial product followed by reduction modulo 0x11b
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (15'(a) << i);
        end
        for (int k = 14; k >= 8; k--) begin
            if (p[k]) p = p ^ (15'h011b << (k - 8));
        end
        return p[7:0];
    endfunction

    // Whole-state MixColumns as a circulant matrix product per column
    function automatic logic [127:0] mixModel(input logic [127:0] s, input logic inv);
        logic [7:0]   row [4];
        logic [127:0] res;
        logic [7:0]   acc;
        if (inv) begin
            row[0] = 8'h0e; row[1] = 8'h0b; row[2] = 8'h0d; row[3] = 8'h09;
        end else begin
            row[0] = 8'h02; row[1] = 8'h03; row[2] = 8'h01; row[3] = 8'h01;
        end
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gmul(row[(k - r + 4) % 4], s[127 - 32*c - 8*k -: 8]);
                end
                res[127 - 32*c - 8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mBusyLeft  = 0;
        mOutValid  = 1'b0;
        mExpState  = '0;
        mExpId     = 1'b0;
        mLastGrant = 1'b1;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model
    task automatic applyStimulus(input logic v0, input logic [127:0] s0, input logic n0,
                                 input logic v1, input logic [127:0] s1, input logic n1,
                                 input logic ordy);
        bit   idle;
        logic g, expR0, expR1;
        @(negedge clk);
        req0_valid = v0; req0_state = s0; req0_inv = n0;
        req1_valid = v1; req1_state = s1; req1_inv = n1;
        out_ready  = ordy;
        #1;
        idle  = (mBusyLeft == 0) && !mOutValid;
        g     = (v0 && v1) ? ~mLastGrant : v1;
        expR0 = idle && v0 && !g;
        expR1 = idle && v1 && g;
        checkOutput("req0_ready", 128'(req0_ready), 128'(expR0));
        checkOutput("req1_ready", 128'(req1_ready), 128'(expR1));
        checkOutput("busy", 128'(busy), 128'(!idle));
        checkOutput("out_valid", 128'(out_valid), 128'(mOutValid));
        if (mOutValid) begin
            checkOutput("out_state", out_state, mExpState);
            checkOutput("out_id", 128'(out_id), 128'(mExpId));
        end
        if (out_valid && ordy) begin
            outStates.push_back(out_state);
            outIds.push_back(out_id);
        end
        if (mOutValid) begin
            if (ordy) mOutValid = 1'b0;
        end else if (mBusyLeft > 0) begin
            mBusyLeft--;
            if (mBusyLeft == 0) mOutValid = 1'b1;
        end else if (expR0 || expR1) begin
            mBusyLeft  = 4;
            mExpState  = mixModel(expR1 ? s1 : s0, (expR1 ? n1 : n0) & INV_ON);
            mExpId     = expR1;
            mLastGrant = expR1;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    localparam logic [127:0] FWD_IN   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FWD_OUT  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] CON0_IN  = 128'hd4d4d4d5_2d26314c_00000000_00000000;
    localparam logic [127:0] CON0_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_00000000;
    localparam logic [127:0] CON1_IN  = 128'hdb135345_00000000_00000000_00000000;
    localparam logic [127:0] CON1_OUT = 128'h8e4da1bc_00000000_00000000_00000000;

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_state = '0;   req1_state = '0;
        req0_inv   = 1'b0; req1_inv   = 1'b0;
        out_ready  = 1'b0;
        modelReset();

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst out_valid", 128'(out_valid), 128'(0));
        checkOutput("rst out_state", out_state, '0);
        checkOutput("rst out_id", 128'(out_id), 128'(0));
        checkOutput("rst busy", 128'(busy), 128'(0));
        rst_n = 1'b1;

        // Contention: both valid continuously, grants alternate starting with 0
        outStates.delete(); outIds.delete();
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, CON0_IN, 1'b0, 1'b1, CON1_IN, 1'b0, 1'b1);
        idleCycles(6);
        checkOutput("contention count", 128'(outStates.size()), 128'(4));
        if (outStates.size() >= 3) begin
            checkOutput("contention r0", outStates[0], CON0_OUT);
            checkOutput("contention id0", 128'(outIds[0]), 128'(0));
            checkOutput("contention r1", outStates[1], CON1_OUT);
            checkOutput("contention id1", 128'(outIds[1]), 128'(1));
            checkOutput("contention id2", 128'(outIds[2]), 128'(0));
        end

        // Single forward transform from requester 0
        outStates.delete(); outIds.delete();
        applyStimulus(1'b1, FWD_IN, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        idleCycles(7);
        checkOutput("single count", 128'(outStates.size()), 128'(1));
        if (outStates.size() >= 1) begin
            checkOutput("single state", outStates[0], FWD_OUT);
            checkOutput("single id", 128'(outIds[0]), 128'(0));
        end

        // Backpressure: result held 10 cycles while requester 1 waits
        applyStimulus(1'b1, CON0_IN, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, CON1_IN, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, CON1_IN, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, CON1_IN, 1'b0, 1'b1);
        idleCycles(7);

        // Reset while BUSY: in-flight result discarded, next tie goes to requester 0
        outStates.delete(); outIds.delete();
        applyStimulus(1'b1, FWD_IN, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        idleCycles(2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst out_valid", 128'(out_valid), 128'(0));
        checkOutput("midrst busy", 128'(busy), 128'(0));
        modelReset();
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, CON0_IN, 1'b0, 1'b1, CON1_IN, 1'b0, 1'b1);
        idleCycles(7);
        checkOutput("midrst count", 128'(outStates.size()), 128'(1));
        if (outIds.size() >= 1) begin
            checkOutput("midrst id", 128'(outIds[0]), 128'(0));
            checkOutput("midrst state", outStates[0], CON0_OUT);
        end

`ifdef MIXCOL_INV_EN
        // Inverse transform on requester 1
        outStates.delete(); outIds.delete();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, FWD_OUT, 1'b1, 1'b1);
        idleCycles(7);
        checkOutput("inv count", 128'(outStates.size()), 128'(1));
        if (outStates.size() >= 1) begin
            checkOutput("inv state", outStates[0], FWD_IN);
            checkOutput("inv id", 128'(outIds[0]), 128'(1));
        end
`endif

        // Randomized traffic with random backpressure
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3) != 0,
                          {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3) != 0);
        end
        idleCycles(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mixcol_arbiter.md
Name: mixcol_arbiter

Overview:
Shares one column-serial MixColumns engine between two requesters, for example two cipher round pipelines.
- Each transaction is a 128-bit AES state, column-major: column c = state[127-32c -: 32], byte 0 at the MSB of each column.
- The engine transforms one 32-bit column per cycle using the forward matrix {02,03,01,01} circulant over GF(2^8), reduction polynomial 0x11b.
- A round-robin arbiter picks the requester, and the result is returned tagged with the requester ID over a valid/ready output.

Parameters:
- NUM_COLS, 4, columns per state. Fixed for AES-128; no other value is supported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has a state to transform
- req0_ready  output  1  requester 0 handshake accepted this cycle
- req0_state  input  128  requester 0 state
- req1_valid  input  1  requester 1 has a state to transform
- req1_ready  output  1  requester 1 handshake accepted this cycle
- req1_state  input  128  requester 1 state
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_state  output  128  transformed state
- out_id  output  1  requester index that owns out_state
- busy  output  1  high whenever FSM not in IDLE

Behaviour:
- Reset: asynchronous, active-low.
  - FSM goes to IDLE; col_cnt = 0.
  - out_valid = 0, out_state = 0, out_id = 0, busy = 0.
  - last_grant = 1, so requester 0 wins the first tie.
- FSM states:
  - IDLE: wait for a request.
  - BUSY: process one column per cycle.
  - DONE: hold the result until the consumer takes it.
- IDLE arbitration (combinational):
  - Exactly one reqN_valid high: grant N.
  - Both high: grant !last_grant.
  - reqN_ready = (state == IDLE) && grant == N && reqN_valid. At most one ready is high in any cycle.
- Accept edge (reqN_valid && reqN_ready):
  - Capture reqN_state into the work register.
  - out_id <= N; last_grant <= N; col_cnt <= 0; go to BUSY.
  - The requester may change its data after the accept edge.
- BUSY, each edge:
  - Column col_cnt of the work register passes through the column mixer; the result is written to the same column of out_state.
  - col_cnt increments. On the edge where col_cnt == 3, go to DONE and set out_valid = 1.
- Latency and throughput:
  - out_valid rises exactly 4 clock edges after the accept edge.
  - Minimum spacing between accepts is 6 cycles: accept, 4 BUSY, 1 DONE handshake.
- DONE:
  - out_valid = 1. out_state and out_id stay stable until out_ready.
  - On out_valid && out_ready: out_valid <= 0, go to IDLE.
  - No new request is accepted in that same cycle; the earliest next accept is the following cycle.
- Backpressure:
  - out_ready low holds DONE indefinitely; both req*_ready stay 0.
  - A waiting requester keeps its valid high. Dropping valid before ready is legal; the request is then simply not taken.
- Fairness: while both requesters are held continuously valid, grants strictly alternate 0, 1, 0, 1, ...
- Column mixer (byte b0..b3 in, r0..r3 out):
  - r0 = 2b0^3b1^b2^b3
  - r1 = b0^2b1^3b2^b3
  - r2 = b0^b1^2b2^3b3
  - r3 = 3b0^b1^b2^2b3
  - xtime(x) = {x[6:0],0} ^ (0x1b if x[7]).
- Reset mid-operation (BUSY or DONE):
  - The in-flight state is discarded; no output is produced for it.
  - Arbitration restarts from last_grant = 1.
- out_state content while out_valid = 0 is undefined to consumers, but must be deterministic (no X after reset).

Optional Feature:
- Macro: MIXCOL_INV_EN.
- When defined:
  - Ports req0_inv and req1_inv (input, 1) are added.
  - The inv bit is captured on accept alongside the state.
  - Captured inv = 1 uses the inverse matrix {0e,0b,0d,09} circulant; inv = 0 uses the forward matrix.
  - Timing and handshake are identical in both modes.
- When undefined: the inv ports do not exist and the forward transform is always used.

Test Plan:
- Single forward transform:
  - Stimulus: req0_state = db135345_f20a225c_01010101_c6c6c6c6, out_ready held at 1.
  - Required: out_state = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_id = 0, out_valid high 4 edges after accept for exactly 1 cycle.
- Contention:
  - Stimulus: req0 state d4d4d4d5_2d26314c_00000000_00000000 and req1 state db135345_00000000_00000000_00000000, both valid at the same time, continuously.
  - Required: first grant 0 with result d5d5d7d6_4d7ebdf8_00000000_00000000; next grant 1 with result 8e4da1bc_00000000_00000000_00000000; grants alternate thereafter.
- Backpressure:
  - Stimulus: out_ready = 0 for 10 cycles after out_valid rises, with req1 valid throughout.
  - Required: out_state and out_id stable, req1_ready = 0 throughout; req1 is accepted the cycle after out_ready is raised.
- Reset in BUSY:
  - Stimulus: drop rst_n two cycles after the accept edge.
  - Required: out_valid = 0 and busy = 0 immediately (asynchronous); no result emitted; the next tie grants requester 0.
- MIXCOL_INV_EN:
  - Stimulus: req1_inv = 1, req1_state = 8e4da1bc_9fdc589d_01010101_c6c6c6c6.
  - Required: out_state = db135345_f20a225c_01010101_c6c6c6c6, out_id = 1.
